bcd_display_scanner: RTL and testbench

- Downstream display stage for the binary-to-BCD converter.
- Consumes its nine BCD digits (BCD0..BCD8) and time-multiplexes them onto a common-anode 9-digit seven-segment display.
- Frame-synchronous snapshot: a digit update mid-frame never tears the displayed number.
- Per-digit dead time suppresses ghosting; optional leading-zero blanking.

---
 rtl/bcd_display_scanner.sv | 166 ++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 9-digit common-anode seven-segment scanner with frame snapshot and dead time.
// Define BCD_LZB_EN to enable leading-zero blanking of digits 1..8.
module bcd_display_scanner #(
   parameter int TICK_DIV    = 5000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       enable,
   input  logic [3:0] BCD0,
   input  logic [3:0] BCD1,
   input  logic [3:0] BCD2,
   input  logic [3:0] BCD3,
   input  logic [3:0] BCD4,
   input  logic [3:0] BCD5,
   input  logic [3:0] BCD6,
   input  logic [3:0] BCD7,
   input  logic [3:0] BCD8,
   output logic [6:0] seg,
   output logic [8:0] an,
   output logic       frame_start
);

   localparam int                CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  DEAD_CNT = CNT_W'(DEAD_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DEAD,
      DRIVE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [3:0]       idx, idx_nxt;
   logic [35:0]      snap, snap_nxt;
   logic [35:0]      bcd_in;
   logic [8:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             fs_nxt;
   logic [3:0]       digit_nxt;
   logic             blank_nxt;

   // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

`ifdef BCD_LZB_EN
   // Digit i>0 is blank when it and every more significant digit are zero.
   function automatic logic lz_blank(input logic [35:0] s, input logic [3:0] i);
      logic nz;
      nz = 1'b0;
      for (int j = 1; j < 9; j++) begin
         if (j >= int'(i) && s[4*j +: 4] != 4'd0) nz = 1'b1;
      end
      return (i != 4'd0) && !nz;
   endfunction
`endif

   assign bcd_in  = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      snap_nxt  = snap;
      fs_nxt    = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               snap_nxt  = bcd_in;
               fs_nxt    = 1'b1;
               cnt_nxt   = '0;
               idx_nxt   = 4'd0;
               state_nxt = (DEAD_CYCLES == 0) ? DRIVE : DEAD;
            end
            DEAD: begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == DEAD_CNT) state_nxt = DRIVE;
            end
            DRIVE: begin
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = (DEAD_CYCLES == 0) ? DRIVE : DEAD;
                  // Snapshot is refreshed only on the frame wrap so a frame never tears.
                  if (idx == 4'd8) begin
                     idx_nxt  = 4'd0;
                     snap_nxt = bcd_in;
                     fs_nxt   = 1'b1;
                  end else begin
                     idx_nxt = idx + 4'd1;
                  end
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = 4'd0;
            end
         endcase
      end
   end

   // Outputs are computed from next-state values so the registered drive lines up with the state.
   always_comb begin
      an_nxt    = 9'h1FF;
      seg_nxt   = 7'h7F;
      digit_nxt = snap_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef BCD_LZB_EN
      blank_nxt = lz_blank(snap_nxt, idx_nxt);
`else
      blank_nxt = 1'b0;
`endif
      if (state_nxt == DRIVE && !blank_nxt) begin
         an_nxt  = ~(9'd1 << idx_nxt);
         seg_nxt = decode(digit_nxt);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 4'd0;
         an          <= 9'h1FF;
         seg         <= 7'h7F;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         an          <= an_nxt;
         seg         <= seg_nxt;
         frame_start <= fs_nxt;
      end
   end

   // Snapshot is pure data; it is always written before it is displayed.
   always_ff @(posedge Clk) begin
      snap <= snap_nxt;
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (TICK_DIV=4, DEAD_CYCLES=1), table vectors plus random scan.
// Honours BCD_LZB_EN in its reference model when the design is built with it.
module tb_bcd_display_scanner;

   localparam int TD   = 4;
   localparam int DC   = 1;
   localparam int FLEN = 9 * TD;

   localparam logic [6:0] SEGTAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        enable;
   logic [35:0] num;
   logic [6:0]  seg;
   logic [8:0]  an;
   logic        frame_start;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model state: time since frame start and the number latched for this frame
   bit          running = 0;
   int          t = 0;
   logic [35:0] msnap = '0;

   bcd_display_scanner #(.TICK_DIV(TD), .DEAD_CYCLES(DC)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .enable(enable),
      .BCD0(num[3:0]),   .BCD1(num[7:4]),   .BCD2(num[11:8]),
      .BCD3(num[15:12]), .BCD4(num[19:16]), .BCD5(num[23:20]),
      .BCD6(num[27:24]), .BCD7(num[31:28]), .BCD8(num[35:32]),
      .seg(seg), .an(an), .frame_start(frame_start));

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge();
      if (!Reset_n || !enable) begin
         running = 0;
      end else if (!running) begin
         running = 1;
         t       = 0;
         msnap   = num;
      end else begin
         t++;
         if (t % FLEN == 0) msnap = num;
      end
   endtask

   task automatic model_out(output logic [8:0] ea, output logic [6:0] es, output logic ef);
      int   slot, pos;
      bit   blank;
      ea = 9'h1FF; es = 7'h7F; ef = 1'b0;
      if (running) begin
         slot = (t / TD) % 9;
         pos  = t % TD;
         ef   = (t % FLEN == 0);
         blank = 0;
`ifdef BCD_LZB_EN
         if (slot > 0 && (msnap >> (4 * slot)) == 36'd0) blank = 1;
`endif
         if (pos >= DC && !blank) begin
            ea = ~(9'd1 << slot);
            es = SEGTAB[msnap[4*slot +: 4]];
         end
      end
   endtask

   task automatic step();
      logic [8:0] ea; logic [6:0] es; logic ef;
      model_edge();
      @(posedge Clk);
      #1;
      cyc++;
      model_out(ea, es, ef);
      chk("model_an", 36'(an), 36'(ea));
      chk("model_seg", 36'(seg), 36'(es));
      chk("model_fs", 36'(frame_start), 36'(ef));
   endtask

   typedef struct {
      string       name;
      logic [35:0] bcd;
      int          slot;
      logic [8:0]  an;
      logic [6:0]  seg;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int first, second;

      vecs[0] = '{"s0_dig8",  36'h650345768, 0, 9'h1FE, 7'b0000000};
      vecs[1] = '{"s2_dig7",  36'h650345768, 2, 9'h1FB, 7'b1111000};
      vecs[2] = '{"s8_dig6",  36'h650345768, 8, 9'h0FF, 7'b0000010};
      vecs[3] = '{"inv_s3",   36'h65034C768, 3, 9'h1F7, 7'b0111111};
      vecs[4] = '{"inv_s4",   36'h65034C768, 4, 9'h1EF, 7'b0011001};
      vecs[6] = '{"lz_s6",    36'h001234593, 6, 9'h1BF, 7'b1111001};
      vecs[8] = '{"zero_s0",  36'h000000000, 0, 9'h1FE, 7'b1000000};
`ifdef BCD_LZB_EN
      vecs[5] = '{"lz_s8",    36'h001234593, 8, 9'h1FF, 7'h7F};
      vecs[7] = '{"lz_s7",    36'h001234593, 7, 9'h1FF, 7'h7F};
      vecs[9] = '{"zero_s5",  36'h000000000, 5, 9'h1FF, 7'h7F};
`else
      vecs[5] = '{"lz_s8",    36'h001234593, 8, 9'h0FF, 7'b1000000};
      vecs[7] = '{"lz_s7",    36'h001234593, 7, 9'h17F, 7'b1000000};
      vecs[9] = '{"zero_s5",  36'h000000000, 5, 9'h1DF, 7'b1000000};
`endif

      // asynchronous reset with no clock edge
      Reset_n = 1'b1; enable = 1'b0; num = '0;
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_an", 36'(an), 36'h1FF);
      chk("rst_seg", 36'(seg), 36'h7F);
      chk("rst_fs", 36'(frame_start), 36'd0);
      step(); step();
      Reset_n = 1'b1;
      repeat (3) step();

      // reset asserted mid-DRIVE in slot 2
      num = 36'h650345768; enable = 1'b1;
      repeat (2 * TD + 2) step();
      chk("pre_rst_an", 36'(an), 36'h1FB);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_an", 36'(an), 36'h1FF);
      chk("mid_rst_seg", 36'(seg), 36'h7F);
      chk("mid_rst_fs", 36'(frame_start), 36'd0);
      running = 0;
      // release with enable already high: first edge starts a frame
      step();
      Reset_n = 1'b1;
      step();
      chk("rel_fs", 36'(frame_start), 36'd1);

      // table-driven slot checks
      for (int v = 0; v < 10; v++) begin
         enable = 1'b0;
         step();
         num = vecs[v].bcd; enable = 1'b1;
         repeat (vecs[v].slot * TD + 3) step();
         chk({vecs[v].name, "_an"}, 36'(an), 36'(vecs[v].an));
         chk({vecs[v].name, "_seg"}, 36'(seg), 36'(vecs[v].seg));
      end

      // frame_start period
      enable = 1'b0; step();
      num = 36'h650345768; enable = 1'b1;
      first = -1; second = -1;
      for (int c = 0; c < 80; c++) begin
         step();
         if (frame_start) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      chk("fs_first", 36'(first), 36'd0);
      chk("fs_period", 36'(second - first), 36'(FLEN));

      // snapshot holds when inputs change mid-frame
      enable = 1'b0; step();
      num = 36'h650345768; enable = 1'b1;
      repeat (3 * TD + 1) step();
      num = 36'h500478987;
      repeat (2) step();
      chk("snap_s3_seg", 36'(seg), 36'(7'b0010010));
      repeat (FLEN + 2 - (3 * TD + 2)) step();
      chk("snap_new_fs_an", 36'(an), 36'h1FE);
      chk("snap_new_seg", 36'(seg), 36'(7'b1111000));

      // enable dropped in slot 5, then re-raised
      enable = 1'b0; step();
      num = 36'h650345768; enable = 1'b1;
      repeat (5 * TD + 2) step();
      enable = 1'b0;
      step();
      chk("drop_an", 36'(an), 36'h1FF);
      chk("drop_fs", 36'(frame_start), 36'd0);
      num = 36'h123456789; enable = 1'b1;
      step();
      chk("rerise_fs", 36'(frame_start), 36'd1);
      step();
      chk("rerise_an", 36'(an), 36'h1FE);
      chk("rerise_seg", 36'(seg), 36'(7'b0010000));

      // randomized scan against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) begin
            for (int d = 0; d < 9; d++) num[4*d +: 4] = 4'($urandom_range(15));
            if ($urandom_range(2) == 0) num = num >> (4 * $urandom_range(8, 1));
         end
         if ($urandom_range(149) == 0) enable = ~enable;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
